// File: rtl/prime_factor_stream.sv
// -----------------------------------------------------------------------------
// prime_factor_stream
//
// Accepts one WIDTH-bit number over a valid/ready handshake. It computes the
// full prime factorisation by trial division, using a bit-serial restoring
// divider that produces one quotient bit per cycle. The prime factors are
// emitted in ascending order, with multiplicity, on a valid/ready output
// stream. The final beat carries out_last, together with the primality flag
// and the factor count.
//
// Numbers 0 and 1 produce a single beat that carries the raw number.
//
// Parameters
//   WIDTH   bit width of the number and of every factor (legal range 4..32)
//   CNT_W   width of factor_count
//
// Optional build macro
//   FACTORIZER_ODD_STEP_EN
//     When defined, the trial divisors after 3 step by 2 (2, 3, 5, 7, 9, ...).
//     When undefined, every integer is tried (2, 3, 4, 5, ...).
//     Both builds emit identical beats. Only the cycle counts differ.
//
// Ports
//   clk           rising-edge clock
//   reset_n       synchronous active-low reset
//   in_valid      a number is presented on 'number'
//   in_ready      block is idle and accepts a number this cycle
//   number        value to factorise
//   out_valid     out_factor holds a valid beat
//   out_ready     consumer accepts the current beat
//   out_factor    prime factor (raw number for inputs 0 and 1)
//   out_last      final beat of the current number
//   is_prime      primality of the number; meaningful with out_last
//   factor_count  factors emitted so far, including the current beat
// -----------------------------------------------------------------------------
module prime_factor_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_factor,
  output logic             out_last,
  output logic             is_prime,
  output logic [CNT_W-1:0] factor_count
);

  localparam int DC_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DIVIDE,
    DECIDE,
    EMIT
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  n_q;        // residual number still to be factorised
  logic [WIDTH-1:0]  d_q;        // current trial divisor
  logic [WIDTH-1:0]  quo_q;      // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]  rem_q;      // partial remainder
  logic [DC_W-1:0]   div_cnt_q;  // quotient bit index within DIVIDE
  logic [CNT_W-1:0]  cnt_q;      // beats already handed off for this number

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------

  // d*d is formed at double width, so the termination test cannot wrap.
  logic [2*WIDTH-1:0] d_sq;
  logic [2*WIDTH-1:0] n_wide;
  assign d_sq   = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};
  assign n_wide = {{WIDTH{1'b0}}, n_q};

  // Restoring-division step. Shift the next dividend bit into the remainder,
  // then trial-subtract the divisor. The remainder is always below d, and d is
  // far below 2^WIDTH. So the borrow out of the extra top bit is an exact
  // "shifted remainder < d" flag.
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] rem_sub;
  logic           rem_ge;
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_sub   = rem_shift - {1'b0, d_q};
  assign rem_ge    = ~rem_sub[WIDTH];

  logic div_last;
  assign div_last = (div_cnt_q == DC_W'(WIDTH - 1));

  // Next trial divisor. Composite divisors can never divide, because their
  // prime factors have already been removed. Skipping even divisors therefore
  // only saves cycles.
  logic [WIDTH-1:0] d_next;
`ifdef FACTORIZER_ODD_STEP_EN
  assign d_next = (d_q == WIDTH'(2)) ? WIDTH'(3) : d_q + WIDTH'(2);
`else
  assign d_next = d_q + WIDTH'(1);
`endif

  // ---------------------------------------------------------------------------
  // Control and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: every register in this block, the datapath included, is assigned
  // with <= only. All reads therefore see the value from before the edge, and
  // the synchronous reset drops any in-flight number from any state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_factor   <= '0;
      is_prime     <= 1'b0;
      factor_count <= '0;
      n_q          <= '0;
      d_q          <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      div_cnt_q    <= '0;
      cnt_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            n_q          <= number;
            d_q          <= WIDTH'(2);
            cnt_q        <= '0;
            in_ready     <= 1'b0;
            is_prime     <= 1'b0;
            factor_count <= '0;
            if (number < WIDTH'(2)) begin
              // 0 and 1 have no prime factors. Echo the raw value as one beat.
              state        <= EMIT;
              out_valid    <= 1'b1;
              out_factor   <= number;
              out_last     <= 1'b1;
              factor_count <= CNT_W'(1);
            end else begin
              state <= CHECK;
            end
          end
        end

        CHECK: begin
          if (d_sq > n_wide) begin
            // No divisor up to sqrt(n) remains, so the residual n is prime.
            // It is the final factor. If nothing was emitted before it, the
            // original number was prime.
            state        <= EMIT;
            out_valid    <= 1'b1;
            out_factor   <= n_q;
            out_last     <= 1'b1;
            factor_count <= cnt_q + CNT_W'(1);
            is_prime     <= (cnt_q == '0);
          end else begin
            rem_q     <= '0;
            quo_q     <= n_q;
            div_cnt_q <= '0;
            state     <= DIVIDE;
          end
        end

        DIVIDE: begin
          quo_q     <= {quo_q[WIDTH-2:0], rem_ge};
          rem_q     <= rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
          div_cnt_q <= div_cnt_q + DC_W'(1);
          if (div_last) begin
            state <= DECIDE;
          end
        end

        DECIDE: begin
          if (rem_q == '0) begin
            // d divides n. Emit it now. The quotient in quo_q becomes the new
            // n once the beat is taken.
            state        <= EMIT;
            out_valid    <= 1'b1;
            out_factor   <= d_q;
            out_last     <= 1'b0;
            factor_count <= cnt_q + CNT_W'(1);
          end else begin
            d_q   <= d_next;
            state <= CHECK;
          end
        end

        EMIT: begin
          // Output fields stay untouched until the consumer takes the beat.
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt_q     <= cnt_q + CNT_W'(1);
            if (out_last) begin
              // is_prime and factor_count are held until the next accept.
              out_last <= 1'b0;
              in_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              // Keep d unchanged, so a repeated factor is found again.
              n_q   <= quo_q;
              state <= CHECK;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prime_factor_stream.sv
// -----------------------------------------------------------------------------
// tb_prime_factor_stream
//
// Self-checking bench for prime_factor_stream. It uses two instances:
//   dut    WIDTH=8, the main scoreboard target
//   dut16  WIDTH=16, used for the large-prime case
// Expected beats come from an arithmetic factorisation model. They are pushed
// to a queue when a number is driven, and popped when the DUT hands a beat
// off. With out_ready held high, the total cycle count is also compared
// against a cycle model of the trial-division schedule.
// -----------------------------------------------------------------------------
module tb_prime_factor_stream;

  localparam int W8  = 8;
  localparam int W16 = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance signals
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W8-1:0] number = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W8-1:0] out_factor;
  logic          out_last;
  logic          is_prime;
  logic [3:0]    factor_count;

  // WIDTH=16 instance signals
  logic           in_valid16 = 1'b0;
  logic           in_ready16;
  logic [W16-1:0] number16 = '0;
  logic           out_valid16;
  logic           out_ready16 = 1'b1;
  logic [W16-1:0] out_factor16;
  logic           out_last16;
  logic           is_prime16;
  logic [4:0]     factor_count16;

  prime_factor_stream #(.WIDTH(W8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .number       (number),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_factor   (out_factor),
    .out_last     (out_last),
    .is_prime     (is_prime),
    .factor_count (factor_count)
  );

  prime_factor_stream #(.WIDTH(W16)) dut16 (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid16),
    .in_ready     (in_ready16),
    .number       (number16),
    .out_valid    (out_valid16),
    .out_ready    (out_ready16),
    .out_factor   (out_factor16),
    .out_last     (out_last16),
    .is_prime     (is_prime16),
    .factor_count (factor_count16)
  );

  typedef struct packed {
    logic [W8-1:0] factor;
    logic          last;
    logic          prime;
    logic [3:0]    cnt;
  } beat_t;

  beat_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int exp_cycles = 0;
  bit lat_chk = 1'b0;
  bit bp_mode = 1'b0;
  bit done = 1'b0;
  bit stalled = 1'b0;
  bit post_chk = 1'b0;
  logic [W8-1:0] held_factor = '0;
  logic          held_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Factorisation model for WIDTH=8. It pushes the expected beats and returns
  // the number of clock edges from the accept edge to the last-beat handshake,
  // assuming out_ready stays high.
  function automatic int model_push(input int num);
    beat_t b;
    int n = num;
    int d = 2;
    int t = 0;
    int k = 0;
    if (num < 2) begin
      b.factor = 8'(num); b.last = 1'b1; b.prime = 1'b0; b.cnt = 4'd1;
      exp_q.push_back(b);
      return 1;
    end
    while (1) begin
      t += 1;                              // CHECK
      if (d * d > n) begin
        k++;
        b.factor = 8'(n); b.last = 1'b1; b.prime = (k == 1); b.cnt = 4'(k);
        exp_q.push_back(b);
        t += 1;                            // EMIT handshake
        break;
      end
      t += W8 + 1;                         // DIVIDE + DECIDE
      if (n % d == 0) begin
        k++;
        b.factor = 8'(d); b.last = 1'b0; b.prime = 1'b0; b.cnt = 4'(k);
        exp_q.push_back(b);
        t += 1;                            // EMIT handshake
        n = n / d;
      end else begin
`ifdef FACTORIZER_ODD_STEP_EN
        d = (d == 2) ? 3 : d + 2;
`else
        d = d + 1;
`endif
      end
    end
    return t;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Random backpressure while bp_mode is set. Otherwise the consumer is
  // always ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (post_chk) begin
        check("ready_after_last", {31'd0, in_ready}, 32'd1);
        check("valid_after_last", {31'd0, out_valid}, 32'd0);
        post_chk = 1'b0;
      end
      if (in_valid && in_ready) accept_cyc = cyc;
      if (stalled && !out_valid) begin
        check("valid_held", 32'd0, 32'd1);
        stalled = 1'b0;
      end
      if (out_valid) begin
        check("busy_in_ready", {31'd0, in_ready}, 32'd0);
        if (stalled) begin
          check("stall_factor", {24'd0, out_factor}, {24'd0, held_factor});
          check("stall_last", {31'd0, out_last}, {31'd0, held_last});
        end
        if (out_ready) begin
          stalled = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {24'd0, out_factor}, 32'hFFFF_FFFF);
          end else begin
            beat_t b;
            b = exp_q.pop_front();
            check("factor", {24'd0, out_factor}, {24'd0, b.factor});
            check("last", {31'd0, out_last}, {31'd0, b.last});
            check("factor_count", {28'd0, factor_count}, {28'd0, b.cnt});
            if (b.last) begin
              check("is_prime", {31'd0, is_prime}, {31'd0, b.prime});
              if (lat_chk) check("latency", cyc - accept_cyc, exp_cycles);
              done = 1'b1;
              post_chk = 1'b1;
            end
          end
        end else begin
          stalled = 1'b1;
          held_factor = out_factor;
          held_last = out_last;
        end
      end
    end
  end

  task automatic send(input int num, input bit bp);
    int budget;
    done = 1'b0;
    exp_cycles = model_push(num);
    lat_chk = !bp;
    bp_mode = bp;
    budget = 0;
    while (!in_ready && budget < 100) begin
      @(posedge clk); #1; budget++;
    end
    check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    number = 8'(num);
    @(posedge clk); #1;
    in_valid = 1'b0;
    budget = 0;
    while (!done && budget < 3000) begin
      @(posedge clk); #1; budget++;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
    check("leftover_beats", exp_q.size(), 32'd0);
    exp_q.delete();
    bp_mode = 1'b0;
  endtask

  initial begin
    int budget;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_factor", {24'd0, out_factor}, 32'd0);
    check("rst_is_prime", {31'd0, is_prime}, 32'd0);
    check("rst_factor_count", {28'd0, factor_count}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    send(12, 1'b0);
    send(97, 1'b0);
    send(0, 1'b0);
    send(1, 1'b0);
    send(255, 1'b1);
    send(4, 1'b0);
    send(128, 1'b1);

    // Reset in the middle of dividing 221
    lat_chk = 1'b0;
    in_valid = 1'b1;
    number = 8'd221;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_factor_count", {28'd0, factor_count}, 32'd0);
    stalled = 1'b0;
    post_chk = 1'b0;
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    send(6, 1'b0);

    // Every 8-bit value
    for (int i = 0; i < 256; i++) send(i, 1'b0);

    // Largest 16-bit prime on the WIDTH=16 instance
    in_valid16 = 1'b1;
    number16 = 16'd65521;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    budget = 0;
    while (!out_valid16 && budget < 20000) begin
      @(posedge clk); #1; budget++;
    end
    check("w16_timeout", {31'd0, out_valid16}, 32'd1);
    check("w16_factor", {16'd0, out_factor16}, 32'd65521);
    check("w16_last", {31'd0, out_last16}, 32'd1);
    check("w16_is_prime", {31'd0, is_prime16}, 32'd1);
    check("w16_factor_count", {27'd0, factor_count16}, 32'd1);
    @(posedge clk); #1;
    check("w16_ready_after", {31'd0, in_ready16}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
